// File: rtl/user_sprite_fetch_if.sv
// ROM-side bus of the user sprite fetch stage: one shared read address, two image data returns.
interface user_sprite_fetch_if;
    logic [18:0] read_address;
    logic [3:0]  rom_left_data;
    logic [3:0]  rom_right_data;

    modport master (output read_address, input rom_left_data, input rom_right_data);
    modport slave  (input read_address, output rom_left_data, output rom_right_data);
endinterface

// File: rtl/user_sprite_fetch.sv
// Per-pixel sprite fetch for the player fish: scan position -> ROM address -> aligned palette index.
// Optional build macro USER_SPRITE_MIRROR_EN: right-facing image is a mirror of the left ROM.
module user_sprite_fetch #(
    parameter int unsigned SPR_W      = 64,
    parameter int unsigned SPR_H      = 48,
    parameter logic [3:0]  TRANSP_IDX = 4'd0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic                facing_right,
    user_sprite_fetch_if.master rom,
    output logic [3:0]          pix_idx,
    output logic                pix_opaque,
    output logic [15:0]         frame_opaque
);
    localparam int unsigned CW   = 11;
    localparam int unsigned AW   = 19;
    localparam int unsigned CNTW = 16;

    logic [9:0]      sx_q, sx_d, sy_q, sy_d;
    logic            sdir_q, sdir_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            in_box_d1_q, in_box_d1_d, in_box_d2_q, in_box_d2_d;
    logic            dir_d1_q, dir_d1_d, dir_d2_q, dir_d2_d;
    logic [3:0]      pix_idx_q, pix_idx_d;
    logic            pix_opaque_q, pix_opaque_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_sum;
    logic [CNTW-1:0] frame_opaque_q, frame_opaque_d;

    logic [CW-1:0]   x_ext, y_ext, sx_ext, sy_ext, col, row, col_eff;
    logic            in_box;
    logic [3:0]      rom_d;

    always_comb begin
        sx_d           = sx_q;
        sy_d           = sy_q;
        sdir_d         = sdir_q;
        frame_opaque_d = frame_opaque_q;

        // New position takes effect only for pixels after the frame_start edge
        if (frame_start) begin
            sx_d   = pos_x;
            sy_d   = pos_y;
            sdir_d = facing_right;
        end

        // 11-bit compare so a sprite hanging off the right/bottom edge clips instead of wrapping
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        sx_ext = {1'b0, sx_q};
        sy_ext = {1'b0, sy_q};
        col    = x_ext - sx_ext;
        row    = y_ext - sy_ext;
        in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + CW'(SPR_W)) &&
                 (y_ext >= sy_ext) && (y_ext < sy_ext + CW'(SPR_H));

        col_eff = col;
`ifdef USER_SPRITE_MIRROR_EN
        if (sdir_q) col_eff = CW'(SPR_W - 1) - col;
`endif
        addr_d = in_box ? (AW'(row) * AW'(SPR_W) + AW'(col_eff)) : '0;

        in_box_d1_d = in_box;
        dir_d1_d    = sdir_q;
        in_box_d2_d = in_box_d1_q;
        dir_d2_d    = dir_d1_q;

`ifdef USER_SPRITE_MIRROR_EN
        rom_d = rom.rom_left_data;
`else
        rom_d = dir_d2_q ? rom.rom_right_data : rom.rom_left_data;
`endif
        pix_idx_d    = in_box_d2_q ? rom_d : 4'd0;
        pix_opaque_d = in_box_d2_q && (rom_d != TRANSP_IDX);

        // Saturating opaque count; a frame_start cycle still contributes its own pixel
        cnt_sum = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(pix_opaque_d);
        cnt_d   = cnt_sum;
        if (frame_start) begin
            frame_opaque_d = cnt_sum;
            cnt_d          = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q           <= '0;
            sy_q           <= '0;
            sdir_q         <= 1'b0;
            addr_q         <= '0;
            in_box_d1_q    <= 1'b0;
            in_box_d2_q    <= 1'b0;
            dir_d1_q       <= 1'b0;
            dir_d2_q       <= 1'b0;
            pix_idx_q      <= '0;
            pix_opaque_q   <= 1'b0;
            cnt_q          <= '0;
            frame_opaque_q <= '0;
        end else begin
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            sdir_q         <= sdir_d;
            addr_q         <= addr_d;
            in_box_d1_q    <= in_box_d1_d;
            in_box_d2_q    <= in_box_d2_d;
            dir_d1_q       <= dir_d1_d;
            dir_d2_q       <= dir_d2_d;
            pix_idx_q      <= pix_idx_d;
            pix_opaque_q   <= pix_opaque_d;
            cnt_q          <= cnt_d;
            frame_opaque_q <= frame_opaque_d;
        end
    end

`ifdef USER_SPRITE_MIRROR_EN
    logic unused_right;
    assign unused_right = ^{rom.rom_right_data, dir_d2_q};
`endif

    assign rom.read_address = addr_q;
    assign pix_idx          = pix_idx_q;
    assign pix_opaque       = pix_opaque_q;
    assign frame_opaque     = frame_opaque_q;
endmodule

// File: tb/tb_user_sprite_fetch.sv
// Scoreboard bench for user_sprite_fetch with a registered behavioural ROM pair.
module tb_user_sprite_fetch;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        facing_right;
    logic [3:0]  pix_idx;
    logic        pix_opaque;
    logic [15:0] frame_opaque;
    logic        stim_valid;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  left_mem  [0:4095];
    logic [3:0]  right_mem [0:4095];
    logic [18:0] q_addr [$];
    logic [4:0]  q_pix  [$];
    logic [15:0] q_fo   [$];
    logic        tag_a, tag_b, tag_c, tag_f;

`ifdef USER_SPRITE_MIRROR_EN
    localparam logic [18:0] A64 = 19'd127;
    localparam logic [3:0]  I64 = 4'd3;
    localparam logic [18:0] A0R = 19'd63;
`else
    localparam logic [18:0] A64 = 19'd64;
    localparam logic [3:0]  I64 = 4'd9;
    localparam logic [18:0] A0R = 19'd0;
`endif

    user_sprite_fetch_if rom_if ();

    user_sprite_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing_right (facing_right),
        .rom          (rom_if),
        .pix_idx      (pix_idx),
        .pix_opaque   (pix_opaque),
        .frame_opaque (frame_opaque)
    );

    always #5 Clk = ~Clk;

    // ROM pair with one cycle of read latency
    always @(posedge Clk) begin
        rom_if.rom_left_data  <= (rom_if.read_address < 19'd3072) ? left_mem[rom_if.read_address[11:0]]  : 4'd0;
        rom_if.rom_right_data <= (rom_if.read_address < 19'd3072) ? right_mem[rom_if.read_address[11:0]] : 4'd0;
    end

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tag_a <= 1'b0; tag_b <= 1'b0; tag_c <= 1'b0; tag_f <= 1'b0;
        end else begin
            tag_a <= stim_valid; tag_b <= tag_a; tag_c <= tag_b; tag_f <= frame_start;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard when each output becomes due
    always @(negedge Clk) begin
        logic [18:0] ea;
        logic [4:0]  ep;
        logic [15:0] ef;
        if (tag_a) begin
            if (q_addr.size() == 0) check("addr_queue_empty", 32'd1, 32'd0);
            else begin ea = q_addr.pop_front(); check("read_address", 32'(rom_if.read_address), 32'(ea)); end
        end
        if (tag_c) begin
            if (q_pix.size() == 0) check("pix_queue_empty", 32'd1, 32'd0);
            else begin
                ep = q_pix.pop_front();
                check("pix_idx", 32'(pix_idx), 32'(ep[3:0]));
                check("pix_opaque", 32'(pix_opaque), 32'(ep[4]));
            end
        end
        if (tag_f) begin
            if (q_fo.size() == 0) check("fo_queue_empty", 32'd1, 32'd0);
            else begin ef = q_fo.pop_front(); check("frame_opaque", 32'(frame_opaque), 32'(ef)); end
        end
    end

    task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic chk,
                       input logic [18:0] ea, input logic [3:0] ei, input logic eo,
                       input logic fs, input logic [15:0] efo);
        DrawX = x; DrawY = y; stim_valid = chk; frame_start = fs;
        if (chk) begin q_addr.push_back(ea); q_pix.push_back({eo, ei}); end
        if (fs) q_fo.push_back(efo);
        @(posedge Clk); #1;
        DrawX = 10'd1023; DrawY = 10'd1023; stim_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y,
                      input logic [18:0] ea, input logic [3:0] ei, input logic eo);
        cyc(x, y, 1'b1, ea, ei, eo, 1'b0, 16'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(10'd1023, 10'd1023, 1'b0, 19'd0, 4'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic fstart(input logic [9:0] x, input logic [9:0] y, input logic fr, input logic [15:0] efo);
        pos_x = x; pos_y = y; facing_right = fr;
        cyc(10'd1023, 10'd1023, 1'b0, 19'd0, 4'd0, 1'b0, 1'b1, efo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_address"}, 32'(rom_if.read_address), 32'd0);
        check({tag, "_pix_idx"}, 32'(pix_idx), 32'd0);
        check({tag, "_pix_opaque"}, 32'(pix_opaque), 32'd0);
        check({tag, "_frame_opaque"}, 32'(frame_opaque), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin left_mem[i] = 4'd0; right_mem[i] = 4'd0; end
        left_mem[0] = 4'd5;  left_mem[3071] = 4'd7; left_mem[64] = 4'd3; left_mem[127] = 4'd3;
        left_mem[63] = 4'd4; left_mem[595] = 4'd6;
        for (int i = 2; i <= 9; i++) left_mem[i] = 4'(i - 1);
        right_mem[64] = 4'd9; right_mem[0] = 4'd4;

        Reset_n = 1'b0; frame_start = 1'b0; stim_valid = 1'b0;
        DrawX = 10'd1023; DrawY = 10'd1023; pos_x = 10'd0; pos_y = 10'd0; facing_right = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Reset_n = 1'b1;
        idle(2);

        // Frame 1: shadow (100,50) left-facing, ten opaque pixels
        fstart(10'd100, 10'd50, 1'b0, 16'd0);
        px(10'd100, 10'd50, 19'd0, 4'd5, 1'b1);
        px(10'd163, 10'd97, 19'd3071, 4'd7, 1'b1);
        px(10'd164, 10'd97, 19'd0, 4'd0, 1'b0);
        px(10'd99,  10'd50, 19'd0, 4'd0, 1'b0);
        px(10'd101, 10'd50, 19'd1, 4'd0, 1'b0);
        for (int i = 2; i <= 9; i++) px(10'(100 + i), 10'd50, 19'(i), 4'(i - 1), 1'b1);
        idle(3);
        fstart(10'd100, 10'd50, 1'b1, 16'd10);

        // Frame 2: right-facing; frame_start edge includes the pixel reaching stage 3
        px(10'd100, 10'd51, A64, I64, 1'b1);
        idle(2);
        px(10'd100, 10'd51, A64, I64, 1'b1);
        idle(1);
        pos_x = 10'd620; pos_y = 10'd470; facing_right = 1'b0;
        cyc(10'd100, 10'd50, 1'b1, A0R, 4'd4, 1'b1, 1'b1, 16'd2);

        // Frame 3: sprite at the screen corner, pos changes without frame_start ignored
        px(10'd639, 10'd479, 19'd595, 4'd6, 1'b1);
        px(10'd0,   10'd0,   19'd0, 4'd0, 1'b0);
        px(10'd0,   10'd479, 19'd0, 4'd0, 1'b0);
        px(10'd619, 10'd470, 19'd0, 4'd0, 1'b0);
        px(10'd620, 10'd469, 19'd0, 4'd0, 1'b0);
        px(10'd620, 10'd470, 19'd0, 4'd5, 1'b1);
        pos_x = 10'd200;
        px(10'd620, 10'd470, 19'd0, 4'd5, 1'b1);
        px(10'd200, 10'd470, 19'd0, 4'd0, 1'b0);
        px(10'd683, 10'd517, 19'd3071, 4'd7, 1'b1);
        px(10'd684, 10'd470, 19'd0, 4'd0, 1'b0);
        idle(3);
        fstart(10'd620, 10'd470, 1'b0, 16'd5);

        // Reset in the middle of a busy pipeline
        repeat (4) px(10'd639, 10'd479, 19'd595, 4'd6, 1'b1);
        #1 Reset_n = 1'b0;
        #1 check_all_zero("midreset");
        q_addr.delete(); q_pix.delete(); q_fo.delete();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Shadow back at (0,0) until the next frame_start
        px(10'd0,  10'd0,  19'd0, 4'd5, 1'b1);
        px(10'd64, 10'd0,  19'd0, 4'd0, 1'b0);
        px(10'd0,  10'd48, 19'd0, 4'd0, 1'b0);
        idle(3);
        fstart(10'd0, 10'd0, 1'b0, 16'd1);
        idle(3);

        for (int i = 0; i < 20 && (q_addr.size() + q_pix.size() + q_fo.size()) != 0; i++) @(posedge Clk);
        check("scoreboard_drained", 32'(q_addr.size() + q_pix.size() + q_fo.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
